// File: rtl/eth_mdio_c45_if.sv
// Register-side request/response bundle of the Clause 22/45 MDIO master.
// The CPU side takes the master modport, the MDIO engine the slave modport.
interface eth_mdio_c45_if;
    logic        usr_start;
    logic        usr_c45;
    logic [1:0]  usr_op;
    logic [4:0]  usr_aphy;
    logic [4:0]  usr_areg;
    logic [15:0] usr_txd;
    logic [15:0] usr_rxd;
    logic        usr_busy;
    logic        usr_done;
    logic        usr_err;

    modport master (
        output usr_start, usr_c45, usr_op, usr_aphy, usr_areg, usr_txd,
        input  usr_rxd, usr_busy, usr_done, usr_err
    );

    modport slave (
        input  usr_start, usr_c45, usr_op, usr_aphy, usr_areg, usr_txd,
        output usr_rxd, usr_busy, usr_done, usr_err
    );
endinterface

// File: rtl/eth_mdio_c45.sv
// MDIO management master: Clause 22 and Clause 45 frames, programmable preamble,
// turnaround check on reads. The tristate buffer lives one level up.
module eth_mdio_c45 #(
    parameter int G_DIV     = 2,
    parameter int G_PRE_LEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    eth_mdio_c45_if.slave usr,
    output logic          p_out_mdio_t,
    output logic          p_out_mdio,
    input  logic          p_in_mdio,
    output logic          p_out_mdc,
    output logic [7:0]    dbg_o
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;

    localparam int              N        = G_PRE_LEN + 32;
    localparam logic [5:0]      BIT_LAST = 6'(N - 1);
    localparam int              PH_W     = (G_DIV > 1) ? $clog2(2 * G_DIV) : 1;
    localparam logic [PH_W-1:0] PH_END   = PH_W'(2 * G_DIV - 1);
    localparam logic [PH_W-1:0] PH_RISE  = PH_W'(G_DIV - 1);

    state_t          state_q;
    logic [5:0]      bitcnt_q;
    logic [PH_W-1:0] ph_q;
    logic            arm_q;
    logic            c45_q;
    logic [1:0]      op_q;
    logic [4:0]      aphy_q;
    logic [4:0]      areg_q;
    logic [15:0]     txd_q;
    logic [15:0]     shreg_q;
    logic            ta_err_q;
    logic            mdc_q;
    logic            mdio_q;
    logic            mdio_t_q;
    logic            busy_q;
    logic            done_q;
    logic            err_q;
    logic [15:0]     rxd_q;

    logic        is_rd_d;
    logic        is_bad_d;
    logic [5:0]  nxt_d;
    logic [31:0] lo_d;
    logic        bit_d;
    logic        rel_d;

    assign is_rd_d  = c45_q ? op_q[1] : (op_q == 2'b10);
    assign is_bad_d = !c45_q && (op_q[0] == op_q[1]);
    // The first bit boundary after a start loads the top bit instead of decrementing.
    assign nxt_d    = arm_q ? BIT_LAST : (bitcnt_q - 6'd1);
    assign lo_d     = {1'b0, !c45_q, op_q, aphy_q, areg_q, 2'b10, txd_q};
    assign bit_d    = (nxt_d >= 6'd32) ? 1'b1 : lo_d[nxt_d[4:0]];
    // Reads hand the line to the PHY from the first TA bit (bitcnt 17) onwards.
    assign rel_d    = is_rd_d && (nxt_d <= 6'd17);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            ph_q     <= '0;
            arm_q    <= 1'b0;
            c45_q    <= 1'b0;
            op_q     <= '0;
            aphy_q   <= '0;
            areg_q   <= '0;
            txd_q    <= '0;
            shreg_q  <= '0;
            ta_err_q <= 1'b0;
            mdc_q    <= 1'b0;
            mdio_q   <= 1'b1;
            mdio_t_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rxd_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (usr.usr_start) begin
                        c45_q    <= usr.usr_c45;
                        op_q     <= usr.usr_op;
                        aphy_q   <= usr.usr_aphy;
                        areg_q   <= usr.usr_areg;
                        txd_q    <= usr.usr_txd;
                        busy_q   <= 1'b1;
                        err_q    <= 1'b0;
                        ta_err_q <= 1'b0;
                        arm_q    <= 1'b1;
                        ph_q     <= PH_END;
                        state_q  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (ph_q == PH_END) begin
                        if (arm_q && is_bad_d) begin
                            arm_q   <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= S_DONE;
                        end else if (!arm_q && (bitcnt_q == 6'd0)) begin
                            mdc_q    <= 1'b0;
                            mdio_q   <= 1'b1;
                            mdio_t_q <= 1'b1;
                            done_q   <= 1'b1;
                            err_q    <= is_rd_d && ta_err_q;
                            if (is_rd_d) rxd_q <= shreg_q;
                            state_q  <= S_DONE;
                        end else begin
                            arm_q    <= 1'b0;
                            bitcnt_q <= nxt_d;
                            ph_q     <= '0;
                            mdc_q    <= 1'b0;
                            mdio_q   <= rel_d ? 1'b1 : bit_d;
                            mdio_t_q <= rel_d;
                        end
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                        // MDC rising edge: the PHY's bit is captured on this same clk edge.
                        if (ph_q == PH_RISE) begin
                            mdc_q <= 1'b1;
                            if (is_rd_d && (bitcnt_q == 6'd16) && p_in_mdio) ta_err_q <= 1'b1;
                            if (is_rd_d && (bitcnt_q <= 6'd15)) shreg_q <= {shreg_q[14:0], p_in_mdio};
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign p_out_mdc     = mdc_q;
    assign p_out_mdio    = mdio_q;
    assign p_out_mdio_t  = mdio_t_q;
    assign usr.usr_rxd   = rxd_q;
    assign usr.usr_busy  = busy_q;
    assign usr.usr_done  = done_q;
    assign usr.usr_err   = err_q;
    assign dbg_o         = {state_q[1:0], bitcnt_q};
endmodule

// File: tb/tb_eth_mdio_c45.sv
// Directed bench for eth_mdio_c45: one instance with a 32-bit preamble, one with
// preamble suppression, a simple PHY responder and hand-computed frame images.
module tb_eth_mdio_c45;
    localparam int GD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    eth_mdio_c45_if if32();
    eth_mdio_c45_if if0();

    logic        pin32, pin0;
    logic        mdc32, mdio32, t32, mdc0, mdio0, t0;
    logic [7:0]  dbg32, dbg0;
    logic        start32_v, start0_v, c45_v;
    logic [1:0]  op_v;
    logic [4:0]  aphy_v, areg_v;
    logic [15:0] txd_v;

    assign if32.usr_start = start32_v;
    assign if32.usr_c45   = c45_v;
    assign if32.usr_op    = op_v;
    assign if32.usr_aphy  = aphy_v;
    assign if32.usr_areg  = areg_v;
    assign if32.usr_txd   = txd_v;
    assign if0.usr_start  = start0_v;
    assign if0.usr_c45    = c45_v;
    assign if0.usr_op     = op_v;
    assign if0.usr_aphy   = aphy_v;
    assign if0.usr_areg   = areg_v;
    assign if0.usr_txd    = txd_v;

    eth_mdio_c45 #(.G_DIV(GD), .G_PRE_LEN(32)) dut32 (
        .clk(clk), .rst(rst), .usr(if32), .p_out_mdio_t(t32), .p_out_mdio(mdio32),
        .p_in_mdio(pin32), .p_out_mdc(mdc32), .dbg_o(dbg32));
    eth_mdio_c45 #(.G_DIV(GD), .G_PRE_LEN(0)) dut0 (
        .clk(clk), .rst(rst), .usr(if0), .p_out_mdio_t(t0), .p_out_mdio(mdio0),
        .p_in_mdio(pin0), .p_out_mdc(mdc0), .dbg_o(dbg0));

    bit          sel_v;
    logic        m_mdc, m_mdio, m_t, m_busy, m_done, m_err;
    logic [15:0] m_rxd;
    assign m_mdc  = sel_v ? mdc0 : mdc32;
    assign m_mdio = sel_v ? mdio0 : mdio32;
    assign m_t    = sel_v ? t0 : t32;
    assign m_busy = sel_v ? if0.usr_busy : if32.usr_busy;
    assign m_done = sel_v ? if0.usr_done : if32.usr_done;
    assign m_err  = sel_v ? if0.usr_err : if32.usr_err;
    assign m_rxd  = sel_v ? if0.usr_rxd : if32.usr_rxd;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [63:0] cap_bits, cap_t;
    int          cap_done_c, cap_ndone, cap_rises, cap_mdc_bad;
    logic        cap_err, cap_busy0, cap_busy_after, cap_ab_mdc, cap_ab_t, cap_ab_busy;
    logic [15:0] cap_rxd;

    task automatic run_frame(input bit sel, input bit c45, input logic [1:0] op,
                             input logic [4:0] aphy, input logic [4:0] areg,
                             input logic [15:0] txd, input int phy_mode,
                             input logic [15:0] phy_data, input int restart_c,
                             input int abort_c);
        int n, budget, pos, k;
        logic prev_mdc, pv;
        n = sel ? 32 : 64;
        budget = 2 * GD * n + 12;
        sel_v = sel;
        cap_bits = '0; cap_t = '0; cap_done_c = -1; cap_ndone = 0; cap_rises = 0;
        cap_mdc_bad = 0; cap_err = 1'b0; cap_rxd = '0; cap_busy_after = 1'bx;
        cap_ab_mdc = 1'bx; cap_ab_t = 1'bx; cap_ab_busy = 1'bx;
        @(negedge clk);
        c45_v = c45; op_v = op; aphy_v = aphy; areg_v = areg; txd_v = txd;
        if (sel) start0_v = 1'b1; else start32_v = 1'b1;
        @(negedge clk);
        start0_v = 1'b0; start32_v = 1'b0;
        cap_busy0 = m_busy;
        prev_mdc = m_mdc;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == abort_c) begin
                rst = 1'b0;
                #1;
                cap_ab_mdc = m_mdc; cap_ab_t = m_t; cap_ab_busy = m_busy;
            end
            if (c == abort_c + 1) rst = 1'b1;
            if (m_mdc && !prev_mdc) cap_rises++;
            prev_mdc = m_mdc;
            k = (c - 1) / (2 * GD);
            if (k < n) begin
                if ((c - 1) % (2 * GD) == GD) begin
                    cap_bits[n-1-k] = m_mdio;
                    cap_t[n-1-k]    = m_t;
                    if (!m_mdc) cap_mdc_bad++;
                end
                if (((c - 1) % (2 * GD) == 0) && m_mdc) cap_mdc_bad++;
            end
            if (c == cap_done_c + 1) cap_busy_after = m_busy;
            if (m_done) begin
                cap_ndone++;
                if (cap_done_c < 0) begin
                    cap_done_c = c; cap_err = m_err; cap_rxd = m_rxd;
                end
            end
            if (c == restart_c) begin
                txd_v = ~txd;
                if (sel) start0_v = 1'b1; else start32_v = 1'b1;
            end
            if (c == restart_c + 1) begin
                start0_v = 1'b0; start32_v = 1'b0;
            end
            // PHY responder: TA = released(1), 0, then data MSB first.
            pos = (c + GD - 1) / (2 * GD);
            pv = 1'b1;
            if (phy_mode == 1) begin
                if (pos == n - 17) pv = 1'b0;
                else if ((pos >= n - 16) && (pos < n)) pv = phy_data[n-1-pos];
            end
            if (sel) pin0 = pv; else pin32 = pv;
        end
        pin0 = 1'b1; pin32 = 1'b1; txd_v = txd;
    endtask

    initial begin
        rst = 1'b0; sel_v = 1'b0;
        start32_v = 1'b0; start0_v = 1'b0; c45_v = 1'b0; op_v = '0;
        aphy_v = '0; areg_v = '0; txd_v = '0; pin32 = 1'b1; pin0 = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_mdc", mdc32, 1'b0);
        check_eq("rst_mdio_t", t32, 1'b1);
        check_eq("rst_mdio", mdio32, 1'b1);
        check_eq("rst_busy", if32.usr_busy, 1'b0);
        check_eq("rst_done", if32.usr_done, 1'b0);
        check_eq("rst_err", if32.usr_err, 1'b0);
        check_eq("rst_rxd", if32.usr_rxd, 16'h0000);
        check_eq("rst_mdio_t0", t0, 1'b1);
        rst = 1'b1;
        @(negedge clk);

        run_frame(1'b0, 1'b0, 2'b01, 5'h01, 5'h04, 16'h01E1, 0, 16'h0, -1, -1);
        check_eq("wr_bits", cap_bits, {32'hFFFF_FFFF, 32'h5092_01E1});
        check_eq("wr_mdio_t", cap_t, 64'h0);
        check_eq("wr_done_cyc", cap_done_c, 257);
        check_eq("wr_ndone", cap_ndone, 1);
        check_eq("wr_err", cap_err, 1'b0);
        check_eq("wr_busy0", cap_busy0, 1'b1);
        check_eq("wr_busy_after", cap_busy_after, 1'b0);
        check_eq("wr_mdc_shape", cap_mdc_bad, 0);
        check_eq("wr_mdc_rises", cap_rises, 64);
        check_eq("wr_rxd_keep", if32.usr_rxd, 16'h0000);

        run_frame(1'b0, 1'b0, 2'b10, 5'h01, 5'h04, 16'h0000, 1, 16'h796D, -1, -1);
        check_eq("rd_mdio_t", cap_t, 64'h3_FFFF);
        check_eq("rd_bits", cap_bits & ~64'h3_FFFF, {32'hFFFF_FFFF, 32'h6090_0000});
        check_eq("rd_done_cyc", cap_done_c, 257);
        check_eq("rd_err", cap_err, 1'b0);
        check_eq("rd_rxd", cap_rxd, 16'h796D);
        check_eq("rd_rxd_hold", if32.usr_rxd, 16'h796D);

        run_frame(1'b0, 1'b0, 2'b10, 5'h01, 5'h04, 16'h0000, 0, 16'h0, -1, -1);
        check_eq("rd1_err", cap_err, 1'b1);
        check_eq("rd1_rxd", cap_rxd, 16'hFFFF);

        run_frame(1'b1, 1'b1, 2'b00, 5'h03, 5'h01, 16'h1234, 0, 16'h0, -1, -1);
        check_eq("c45a_bits", cap_bits, 64'h0186_1234);
        check_eq("c45a_mdio_t", cap_t, 64'h0);
        check_eq("c45a_done_cyc", cap_done_c, 129);
        check_eq("c45a_err", cap_err, 1'b0);
        check_eq("c45a_rises", cap_rises, 32);
        check_eq("c45a_rxd", if0.usr_rxd, 16'h0000);

        run_frame(1'b0, 1'b0, 2'b01, 5'h01, 5'h04, 16'h01E1, 0, 16'h0, 41, -1);
        check_eq("rs_bits", cap_bits, {32'hFFFF_FFFF, 32'h5092_01E1});
        check_eq("rs_ndone", cap_ndone, 1);
        check_eq("rs_done_cyc", cap_done_c, 257);
        check_eq("rs_rxd_keep", if32.usr_rxd, 16'hFFFF);

        run_frame(1'b0, 1'b0, 2'b11, 5'h01, 5'h04, 16'h0000, 0, 16'h0, -1, -1);
        check_eq("inv_done_cyc", cap_done_c, 1);
        check_eq("inv_err", cap_err, 1'b1);
        check_eq("inv_rises", cap_rises, 0);
        check_eq("inv_ndone", cap_ndone, 1);
        check_eq("inv_rxd_keep", if32.usr_rxd, 16'hFFFF);

        run_frame(1'b0, 1'b0, 2'b10, 5'h01, 5'h04, 16'h0000, 1, 16'h796D, -1, 163);
        check_eq("ab_mdc", cap_ab_mdc, 1'b0);
        check_eq("ab_mdio_t", cap_ab_t, 1'b1);
        check_eq("ab_busy", cap_ab_busy, 1'b0);
        check_eq("ab_ndone", cap_ndone, 0);
        check_eq("ab_rxd", if32.usr_rxd, 16'h0000);

        run_frame(1'b0, 1'b0, 2'b01, 5'h01, 5'h04, 16'h01E1, 0, 16'h0, -1, -1);
        check_eq("post_bits", cap_bits, {32'hFFFF_FFFF, 32'h5092_01E1});
        check_eq("post_done_cyc", cap_done_c, 257);
        check_eq("post_err", cap_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/eth_mdio_c45.md
Name: eth_mdio_c45

Overview:
Parametrised MDIO management master, successor to the Clause-22-only controller. Adds Clause 45 framing (address, write, read, post-read-increment) and a configurable preamble length, including suppression. It also gains a busy/done/err handshake and turnaround (TA) checking on reads. Sits between the register/CPU side and the PHY MDC/MDIO pins; the top level owns the tristate buffer.

Parameters:
G_DIV, 2, MDC half-period in clk cycles (>=1); MDC period = 2*G_DIV clk
G_PRE_LEN, 32, preamble length in bits (0..32); 0 = preamble suppression

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
usr_start  in  1  request; sampled only while idle
usr_c45  in  1  0 = Clause 22 frame (ST=01), 1 = Clause 45 frame (ST=00)
usr_op  in  2  OP field; C22: 01 write, 10 read; C45: 00 addr, 01 write, 11 read, 10 post-read-inc
usr_aphy  in  5  PHYAD / PRTAD
usr_areg  in  5  REGAD / DEVAD
usr_txd  in  16  write data or C45 address
usr_rxd  out  16  read data
usr_busy  out  1  transaction in progress
usr_done  out  1  1-clk completion pulse
usr_err  out  1  error flag, valid with usr_done
p_out_mdio_t  out  1  1 = release MDIO (input), 0 = drive
p_out_mdio  out  1  MDIO output value
p_in_mdio  in  1  MDIO input
p_out_mdc  out  1  MDC
dbg_o  out  8  {state[1:0], bitcnt[5:0]}

Behaviour:
- Reset (rst=0, async) forces: mdc=0, mdio_t=1, mdio=1, busy=0, done=0, err=0, rxd=0x0000, state IDLE. Reset mid-frame aborts immediately; no done pulse.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE, usr_start=1 at edge E0: latch c45/op/aphy/areg/txd; busy=1 from E0.
- Start while busy is ignored; new inputs are not latched.
- Invalid op (c45=0 and op in {00,11}): no MDC activity. Go to DONE; done=1 and err=1 for the cycle after edge E0+1.
- Frame layout: G_PRE_LEN ones, ST(2), OP(2), AD1(5), AD2(5), TA(2), DATA(16), sent MSB first.
- Frame length N = G_PRE_LEN+32 bits; bitcnt counts down from N-1 to 0.
- Each bit starts at edge E0+1+k*2*G_DIV: mdc=0 for G_DIV clk, then mdc=1 for G_DIV clk.
- Output bit changes only at the start of a bit (MDC falling edge).
- Write/addr frames: mdio_t=0 for all bits; TA driven as 10; DATA = latched txd.
- Read frames (C22 op 10, C45 op 11/10): mdio_t=0 through AD2, then mdio_t=1 from the first TA bit to the end of the frame.
- Read sampling: p_in_mdio is sampled on the clk edge where mdc goes 0->1.
- TA check: second TA bit sampled !=0 sets err.
- DATA bits are shifted into a read shift register.
- Completion: after the last bit's high phase, the FSM enters DONE at edge E0+1+N*2*G_DIV. done=1 for exactly that cycle, then IDLE with busy=0.
- On read completion, rxd is updated to the shifted value in the done cycle and held until the next read completes. It is updated even when err=1.
- On write completion, rxd is unchanged and err=0.
- Between frames: mdc=0, mdio_t=1, mdio=1.
- A new start is accepted on the cycle after done deasserts; back-to-back frames have at least a 1-clk gap.

Test Plan:
- C22 write, G_DIV=2, G_PRE_LEN=32, aphy=01, areg=04, txd=0x01E1 -> MDIO bitstream is 32x1, 01, 01, 00001, 00100, 10, 0000000111100001. MDC period is 4 clk, done at E0+257, err=0, mdio_t=0 throughout.
- C22 read, PHY model drives TA=z0 and data 0x796D -> mdio_t=1 from bit 46, rxd=0x796D, err=0, done at E0+257.
- C22 read with p_in_mdio tied 1 -> err=1, rxd=0xFFFF. Then C45 addr frame (c45=1, op=00, txd=0x1234) with G_PRE_LEN=0 -> ST=00, no preamble, done at E0+129.
- usr_start pulsed again at bit 10 of a frame -> ignored, exactly one done. Invalid C22 op=11 -> no MDC toggles, done with err=1 one cycle after E0.
- rst=0 at bit 40 of a read -> mdc=0, mdio_t=1, busy=0 immediately, no done. Next write after reset completes normally.
